wf_barrier_arbiter: RTL and testbench

WF_BARRIER_ARBITER -- requirements
Module: wf_barrier_arbiter

---
 rtl/wf_barrier_arbiter.sv | 97 +++++++++
 tb/tb_wf_barrier_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wf_barrier_arbiter.sv
// Per-CU wavefront issue arbiter: round-robin grant among ready wavefronts,
// with priority for wavefronts just released from a barrier.
module wf_barrier_arbiter #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WF-1:0] wf_ready,
    input  logic [NUM_WF-1:0] barrier_wait_arry,
    input  logic              arb_accept,
    output logic              arb_valid,
    output logic [WFID_W-1:0] arb_wfid,
    output logic [NUM_WF-1:0] release_pending
);

    localparam logic [WFID_W-1:0] LAST_ID = WFID_W'(NUM_WF - 1);

    logic              arb_valid_q, arb_valid_d;
    logic [WFID_W-1:0] arb_wfid_q, arb_wfid_d;
    logic [WFID_W-1:0] ptr_q, ptr_d;
    logic [NUM_WF-1:0] prev_bw_q, prev_bw_d;
    logic [NUM_WF-1:0] release_pending_q, release_pending_d;

    logic              accepted;
    logic              load;
    logic [NUM_WF-1:0] accept_mask;
    logic [NUM_WF-1:0] eligible;
    logic [NUM_WF-1:0] tier;
    logic [NUM_WF-1:0] released;
    logic [WFID_W-1:0] idx;
    logic [WFID_W-1:0] winner;
    logic              found;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        accepted    = arb_valid_q & arb_accept;
        load        = ~arb_valid_q | arb_accept;
        accept_mask = '0;
        if (accepted) begin
            accept_mask[arb_wfid_q] = 1'b1;
        end

        eligible = wf_ready & ~barrier_wait_arry & ~accept_mask;
        tier     = ((eligible & release_pending_q) != '0) ? (eligible & release_pending_q) : eligible;

        // Walk ptr+1 .. ptr with an explicit wrap; ids past NUM_WF-1 never appear.
        found  = 1'b0;
        winner = arb_wfid_q;
        idx    = ptr_q;
        for (int k = 0; k < NUM_WF; k++) begin
            idx = (idx == LAST_ID) ? '0 : idx + 1'b1;
            if (!found && tier[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end

        arb_valid_d = arb_valid_q;
        arb_wfid_d  = arb_wfid_q;
        if (load) begin
            arb_valid_d = found;
            if (found) begin
                arb_wfid_d = winner;
            end
        end

        ptr_d             = accepted ? arb_wfid_q : ptr_q;
        released          = prev_bw_q & ~barrier_wait_arry;
        release_pending_d = (release_pending_q & ~accept_mask) | released;
        prev_bw_d         = barrier_wait_arry;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_valid_q       <= 1'b0;
            arb_wfid_q        <= '0;
            ptr_q             <= LAST_ID;
            prev_bw_q         <= '0;
            release_pending_q <= '0;
        end else begin
            arb_valid_q       <= arb_valid_d;
            arb_wfid_q        <= arb_wfid_d;
            ptr_q             <= ptr_d;
            prev_bw_q         <= prev_bw_d;
            release_pending_q <= release_pending_d;
        end
    end

    assign arb_valid       = arb_valid_q;
    assign arb_wfid        = arb_wfid_q;
    assign release_pending = release_pending_q;

endmodule

// File: tb/tb_wf_barrier_arbiter.sv
// Self-checking bench for wf_barrier_arbiter: directed scenarios plus random
// traffic compared against a behavioural model of the arbitration rules.
module tb_wf_barrier_arbiter;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_WF-1:0] wf_ready = '0;
    logic [NUM_WF-1:0] barrier_wait_arry = '0;
    logic              arb_accept = 1'b0;
    logic              arb_valid;
    logic [WFID_W-1:0] arb_wfid;
    logic [NUM_WF-1:0] release_pending;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    bit              m_valid;
    int              m_wfid;
    int              m_ptr;
    bit [NUM_WF-1:0] m_prev;
    bit [NUM_WF-1:0] m_rp;

    wf_barrier_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .wf_ready         (wf_ready),
        .barrier_wait_arry(barrier_wait_arry),
        .arb_accept       (arb_accept),
        .arb_valid        (arb_valid),
        .arb_wfid         (arb_wfid),
        .release_pending  (release_pending)
    );

    always #5 clk = ~clk;

    function automatic bit is_elig(int i, bit took);
        return wf_ready[i] && !barrier_wait_arry[i] && !(took && i == m_wfid);
    endfunction

    // Advance model and DUT by one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        bit              took;
        bit              any_rel;
        int              pick;
        bit              n_valid;
        int              n_wfid;
        int              n_ptr;
        bit [NUM_WF-1:0] n_prev;
        bit [NUM_WF-1:0] n_rp;
        took    = m_valid && arb_accept;
        any_rel = 1'b0;
        for (int i = 0; i < NUM_WF; i++) begin
            if (is_elig(i, took) && m_rp[i]) any_rel = 1'b1;
        end
        pick = -1;
        for (int k = 1; k <= NUM_WF; k++) begin
            int id;
            id = (m_ptr + k) % NUM_WF;
            if (pick < 0 && is_elig(id, took) && (!any_rel || m_rp[id])) pick = id;
        end
        n_valid = m_valid;
        n_wfid  = m_wfid;
        if (!m_valid || arb_accept) begin
            n_valid = (pick >= 0);
            if (pick >= 0) n_wfid = pick;
        end
        n_ptr  = took ? m_wfid : m_ptr;
        n_prev = barrier_wait_arry;
        for (int i = 0; i < NUM_WF; i++) begin
            n_rp[i] = (m_rp[i] && !(took && i == m_wfid)) || (m_prev[i] && !barrier_wait_arry[i]);
        end
        if (rst) begin
            n_valid = 1'b0;
            n_wfid  = 0;
            n_ptr   = NUM_WF - 1;
            n_prev  = '0;
            n_rp    = '0;
        end
        @(posedge clk);
        m_valid = n_valid;
        m_wfid  = n_wfid;
        m_ptr   = n_ptr;
        m_prev  = n_prev;
        m_rp    = n_rp;
        #1;
    endtask

    task automatic apply_reset();
        rst               = 1'b1;
        wf_ready          = '0;
        barrier_wait_arry = '0;
        arb_accept        = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        arb_accept = 1'b1;
        wf_ready   = '1;
        tick();
        vectors++;
        if (arb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %0b want 0", arb_valid);
        end
        vectors++;
        if (arb_wfid !== '0) begin
            miscompares++;
            $display("FAIL reset_wfid: got %0d want 0", arb_wfid);
        end
        vectors++;
        if (release_pending !== '0) begin
            miscompares++;
            $display("FAIL reset_release_pending: got %h want 0", release_pending);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_ids[5] = '{0, 5, 39, 0, 5};
        apply_reset();
        wf_ready   = (40'd1 << 0) | (40'd1 << 5) | (40'd1 << 39);
        arb_accept = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (arb_valid !== 1'b1 || arb_wfid !== 6'(exp_ids[i])) begin
                miscompares++;
                $display("FAIL round_robin[%0d]: got valid=%0b id=%0d want valid=1 id=%0d",
                         i, arb_valid, arb_wfid, exp_ids[i]);
            end
        end
    endtask

    task automatic test_hold_then_accept();
        apply_reset();
        wf_ready   = 40'd1 << 7;
        arb_accept = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (arb_valid !== 1'b1 || arb_wfid !== 6'd7) begin
                miscompares++;
                $display("FAIL hold[%0d]: got valid=%0b id=%0d want valid=1 id=7", i, arb_valid, arb_wfid);
            end
        end
        arb_accept = 1'b1;
        tick();
        vectors++;
        if (arb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_accept_bubble: got valid=%0b want 0", arb_valid);
        end
        tick();
        vectors++;
        if (arb_valid !== 1'b1 || arb_wfid !== 6'd7) begin
            miscompares++;
            $display("FAIL single_regrant: got valid=%0b id=%0d want valid=1 id=7", arb_valid, arb_wfid);
        end
        arb_accept = 1'b0;
    endtask

    task automatic test_barrier_release();
        apply_reset();
        wf_ready          = (40'd1 << 3) | (40'd1 << 10);
        barrier_wait_arry = 40'd1 << 10;
        arb_accept        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (arb_valid === 1'b1 && arb_wfid !== 6'd3) begin
                miscompares++;
                $display("FAIL barrier_blocks_10[%0d]: got id=%0d want 3", i, arb_wfid);
            end
        end
        barrier_wait_arry = '0;
        tick();
        vectors++;
        if (release_pending[10] !== 1'b1) begin
            miscompares++;
            $display("FAIL release_set_10: got %0b want 1", release_pending[10]);
        end
        for (int k = 0; k < 4 && arb_valid !== 1'b1; k++) tick();
        vectors++;
        if (arb_valid !== 1'b1 || arb_wfid !== 6'd10) begin
            miscompares++;
            $display("FAIL release_priority: got valid=%0b id=%0d want valid=1 id=10", arb_valid, arb_wfid);
        end
        tick();
        vectors++;
        if (release_pending[10] !== 1'b0) begin
            miscompares++;
            $display("FAIL release_clear_10: got %0b want 0", release_pending[10]);
        end
    endtask

    task automatic test_group_release();
        int exp_ids[4] = '{2, 3, 1, 20};
        apply_reset();
        wf_ready   = 40'd1 << 1;
        arb_accept = 1'b0;
        tick();
        wf_ready          = 40'hE;
        barrier_wait_arry = 40'hE;
        arb_accept        = 1'b1;
        tick();
        barrier_wait_arry = '0;
        wf_ready          = 40'hE | (40'd1 << 20);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                vectors++;
                if (release_pending !== 40'hE) begin
                    miscompares++;
                    $display("FAIL group_release_bits: got %h want 000000000e", release_pending);
                end
            end
            vectors++;
            if (arb_valid !== 1'b1 || arb_wfid !== 6'(exp_ids[i])) begin
                miscompares++;
                $display("FAIL group_order[%0d]: got valid=%0b id=%0d want valid=1 id=%0d",
                         i, arb_valid, arb_wfid, exp_ids[i]);
            end
        end
    endtask

    task automatic test_hold_under_change();
        apply_reset();
        wf_ready   = 40'd1 << 12;
        arb_accept = 1'b0;
        tick();
        wf_ready          = '0;
        barrier_wait_arry = 40'd1 << 12;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (arb_valid !== 1'b1 || arb_wfid !== 6'd12) begin
                miscompares++;
                $display("FAIL hold_12[%0d]: got valid=%0b id=%0d want valid=1 id=12", i, arb_valid, arb_wfid);
            end
        end
        rst        = 1'b1;
        arb_accept = 1'b1;
        tick();
        vectors++;
        if (arb_valid !== 1'b0 || release_pending !== '0) begin
            miscompares++;
            $display("FAIL reset_discards_grant: got valid=%0b rp=%h want valid=0 rp=0", arb_valid, release_pending);
        end
        rst        = 1'b0;
        arb_accept = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        wf_ready   = 40'd1 << 39;
        arb_accept = 1'b0;
        tick();
        wf_ready   = (40'd1 << 0) | (40'd1 << 38);
        arb_accept = 1'b1;
        tick();
        vectors++;
        if (arb_valid !== 1'b1 || arb_wfid !== 6'd0) begin
            miscompares++;
            $display("FAIL wrap_first: got valid=%0b id=%0d want valid=1 id=0", arb_valid, arb_wfid);
        end
        tick();
        vectors++;
        if (arb_valid !== 1'b1 || arb_wfid !== 6'd38) begin
            miscompares++;
            $display("FAIL wrap_second: got valid=%0b id=%0d want valid=1 id=38", arb_valid, arb_wfid);
        end
    endtask

    task automatic test_random();
        logic [63:0] r;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            r          = {$urandom(), $urandom()};
            wf_ready   = r[NUM_WF-1:0] & {$urandom(), 8'hff};
            arb_accept = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 1) == 0) barrier_wait_arry[$urandom_range(0, NUM_WF-1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) barrier_wait_arry = '0;
            tick();
            vectors++;
            if (arb_valid !== m_valid || arb_wfid !== 6'(m_wfid) || release_pending !== m_rp) begin
                miscompares++;
                $display("FAIL random[%0d]: got valid=%0b id=%0d rp=%h want valid=%0b id=%0d rp=%h",
                         c, arb_valid, arb_wfid, release_pending, m_valid, m_wfid, m_rp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_valid = 1'b0;
        m_wfid  = 0;
        m_ptr   = NUM_WF - 1;
        m_prev  = '0;
        m_rp    = '0;
        #1;
        test_reset();
        test_round_robin();
        test_hold_then_accept();
        test_barrier_release();
        test_group_release();
        test_hold_under_change();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
